// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD result display: state encodings, HD44780
// command bytes, ASCII constants and the line-1 byte formatter.
package lcd_pkg;

    typedef enum logic [2:0] {
        ESPERA_INIT,
        INIT,
        OCIOSO,
        CONVERTE,
        ESCREVE
    } estado_t;

    typedef enum logic [1:0] {
        FASE_SETUP,
        FASE_PULSO,
        FASE_ESPERA
    } fase_t;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_LINHA1       = 8'h80;

    localparam logic [7:0] ASCII_ESPACO = 8'h20;
    localparam logic [7:0] ASCII_MENOS  = 8'h2D;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    localparam int N_CMD_INIT      = 4;
    localparam int N_BYTES_ESCREVE = 7;

    function automatic logic [7:0] cmd_init(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = CMD_FUNCTION_SET;
            3'd1:    cmd = CMD_DISPLAY_ON;
            3'd2:    cmd = CMD_ENTRY_MODE;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] digito(input logic [3:0] d, input logic branco);
        return branco ? ASCII_ESPACO : 8'(ASCII_ZERO + {4'h0, d});
    endfunction

    // Returns {RS, data} for byte idx of the line-1 rewrite. A zero magnitude
    // never shows a minus, and only digits above the units can be blanked.
    function automatic logic [8:0] byte_escreve(input logic [2:0] idx,
                                                input logic [19:0] bcd,
                                                input logic neg);
        logic [4:1] lz;
        logic [8:0] res;
        lz[4] = (bcd[19:16] == 4'd0);
        lz[3] = lz[4] && (bcd[15:12] == 4'd0);
        lz[2] = lz[3] && (bcd[11:8] == 4'd0);
        lz[1] = lz[2] && (bcd[7:4] == 4'd0);
        case (idx)
            3'd0:    res = {1'b0, CMD_LINHA1};
            3'd1:    res = {1'b1, (neg && (bcd != 20'd0)) ? ASCII_MENOS : ASCII_ESPACO};
            3'd2:    res = {1'b1, digito(bcd[19:16], lz[4])};
            3'd3:    res = {1'b1, digito(bcd[15:12], lz[3])};
            3'd4:    res = {1'b1, digito(bcd[11:8], lz[2])};
            3'd5:    res = {1'b1, digito(bcd[7:4], lz[1])};
            default: res = {1'b1, digito(bcd[3:0], 1'b0)};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bin_para_bcd.sv
// Sequential double-dabble: converts a 16-bit binary value to 5 BCD digits,
// one shift per clock, pulsing pronto the cycle after the 16th shift.
module bin_para_bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicia,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        pronto
);

    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_pronto;
    logic [15:0] w_ajuste;

    // The top digit never reaches 5 before a shift when the input fits in 16 bits.
    always_comb begin
        w_ajuste = r_bcd[15:0];
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_ajuste[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_pronto <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            if (inicia) begin
                r_bin <= bin;
                r_bcd <= '0;
                r_cnt <= 5'd16;
            end else if (r_cnt != 5'd0) begin
                r_bcd <= {r_bcd[18:16], w_ajuste, r_bin[15]};
                r_bin <= {r_bin[14:0], 1'b0};
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1)
                    r_pronto <= 1'b1;
            end
        end
    end

    assign bcd    = r_bcd;
    assign pronto = r_pronto;

endmodule

// File: rtl/lcd_resultado.sv
// Drives an HD44780 LCD in 8-bit mode: power-on init, then rewrites line 1
// with sign and 5-digit decimal whenever the signed-magnitude input changes.
module lcd_resultado
    import lcd_pkg::*;
#(
    parameter int DELAY_INIT  = 750000,
    parameter int DELAY_CMD   = 2000,
    parameter int DELAY_CLEAR = 82000,
    parameter int EN_HIGH     = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] saida,
    input  logic        sinal_saida,
    output logic [7:0]  data,
    output logic        EN,
    output logic        RS,
    output logic        RW,
    output logic        ocupado
);

    localparam int MAX_A = (DELAY_INIT > DELAY_CLEAR) ? DELAY_INIT : DELAY_CLEAR;
    localparam int MAX_B = (DELAY_CMD > EN_HIGH) ? DELAY_CMD : EN_HIGH;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_D + 1);

    localparam logic [CW-1:0] FIM_INIT  = CW'(DELAY_INIT - 1);
    localparam logic [CW-1:0] FIM_PULSO = CW'(EN_HIGH - 1);
    localparam logic [CW-1:0] FIM_CMD   = CW'(DELAY_CMD - 1);
    localparam logic [CW-1:0] FIM_CLEAR = CW'(DELAY_CLEAR - 1);

    estado_t       r_estado, w_estado_nxt;
    fase_t         r_fase, w_fase_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_rs, w_rs_nxt;
    logic          r_en, w_en_nxt;
    logic          r_ocupado, w_ocupado_nxt;
    logic [16:0]   r_ultimo, w_ultimo_nxt;

    logic          w_inicia;
    logic          w_pronto;
    logic [19:0]   w_bcd;
    logic [16:0]   w_entrada;
    logic          w_fim_espera;
    logic          w_ultimo_byte;
    logic [8:0]    w_byte_prox;

    bin_para_bcd u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .inicia (w_inicia),
        .bin    (saida),
        .bcd    (w_bcd),
        .pronto (w_pronto)
    );

    assign w_entrada     = {sinal_saida, saida};
    assign w_fim_espera  = (!r_rs && r_data == CMD_CLEAR) ? (r_cnt == FIM_CLEAR)
                                                          : (r_cnt == FIM_CMD);
    assign w_ultimo_byte = (r_estado == INIT) ? (r_idx == 3'(N_CMD_INIT - 1))
                                              : (r_idx == 3'(N_BYTES_ESCREVE - 1));
    assign w_byte_prox   = (r_estado == INIT) ? {1'b0, cmd_init(r_idx + 3'd1)}
                                              : byte_escreve(r_idx + 3'd1, w_bcd, r_ultimo[16]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= ESPERA_INIT;
            r_fase    <= FASE_SETUP;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= 8'h00;
            r_rs      <= 1'b0;
            r_en      <= 1'b0;
            r_ocupado <= 1'b1;
            r_ultimo  <= '0;
        end else begin
            r_estado  <= w_estado_nxt;
            r_fase    <= w_fase_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_data    <= w_data_nxt;
            r_rs      <= w_rs_nxt;
            r_en      <= w_en_nxt;
            r_ocupado <= w_ocupado_nxt;
            r_ultimo  <= w_ultimo_nxt;
        end
    end

    always_comb begin
        w_estado_nxt  = r_estado;
        w_fase_nxt    = r_fase;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_data_nxt    = r_data;
        w_rs_nxt      = r_rs;
        w_en_nxt      = r_en;
        w_ocupado_nxt = r_ocupado;
        w_ultimo_nxt  = r_ultimo;
        w_inicia      = 1'b0;

        case (r_estado)
            ESPERA_INIT: begin
                if (r_cnt == FIM_INIT) begin
                    w_estado_nxt = INIT;
                    w_fase_nxt   = FASE_SETUP;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = '0;
                    w_data_nxt   = cmd_init(3'd0);
                    w_rs_nxt     = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            // Both byte-writing states share the SETUP / PULSE / HOLD sequencer.
            INIT, ESCREVE: begin
                case (r_fase)
                    FASE_SETUP: begin
                        w_en_nxt   = 1'b1;
                        w_fase_nxt = FASE_PULSO;
                        w_cnt_nxt  = '0;
                    end
                    FASE_PULSO: begin
                        if (r_cnt == FIM_PULSO) begin
                            w_en_nxt   = 1'b0;
                            w_fase_nxt = FASE_ESPERA;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        if (!w_fim_espera) begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end else if (!w_ultimo_byte) begin
                            w_idx_nxt  = r_idx + 3'd1;
                            w_fase_nxt = FASE_SETUP;
                            w_cnt_nxt  = '0;
                            w_rs_nxt   = w_byte_prox[8];
                            w_data_nxt = w_byte_prox[7:0];
                        end else if (r_estado == INIT) begin
                            w_ultimo_nxt = w_entrada;
                            w_inicia     = 1'b1;
                            w_estado_nxt = CONVERTE;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_estado_nxt  = OCIOSO;
                            w_ocupado_nxt = 1'b0;
                            w_cnt_nxt     = '0;
                        end
                    end
                endcase
            end

            OCIOSO: begin
                if (w_entrada != r_ultimo) begin
                    w_ultimo_nxt  = w_entrada;
                    w_inicia      = 1'b1;
                    w_estado_nxt  = CONVERTE;
                    w_ocupado_nxt = 1'b1;
                end
            end

            CONVERTE: begin
                if (w_pronto) begin
                    w_estado_nxt = ESCREVE;
                    w_fase_nxt   = FASE_SETUP;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = '0;
                    {w_rs_nxt, w_data_nxt} = byte_escreve(3'd0, w_bcd, r_ultimo[16]);
                end
            end

            default: w_estado_nxt = ESPERA_INIT;
        endcase
    end

    assign data    = r_data;
    assign EN      = r_en;
    assign RS      = r_rs;
    assign RW      = 1'b0;
    assign ocupado = r_ocupado;

endmodule

// File: tb/tb_lcd_resultado.sv
// Directed and random checks of lcd_resultado against a decimal formatting
// model; every byte latched on a rising EN is compared with the expected stream.
module tb_lcd_resultado;

    localparam int P_INIT  = 20;
    localparam int P_CMD   = 4;
    localparam int P_CLEAR = 8;
    localparam int P_EN    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] saida;
    logic        sinal_saida;
    logic [7:0]  data;
    logic        EN;
    logic        RS;
    logic        RW;
    logic        ocupado;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    logic       prev_en = 1'b0;
    logic [8:0] latched = '0;

    bit last_neg;
    int last_mag;

    always #5 clk = ~clk;

    lcd_resultado #(
        .DELAY_INIT  (P_INIT),
        .DELAY_CMD   (P_CMD),
        .DELAY_CLEAR (P_CLEAR),
        .EN_HIGH     (P_EN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .saida       (saida),
        .sinal_saida (sinal_saida),
        .data        (data),
        .EN          (EN),
        .RS          (RS),
        .RW          (RW),
        .ocupado     (ocupado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Capture each byte on the rising EN and require data/RS to hold while EN is high.
    always @(negedge clk) begin
        if (EN === 1'b1) begin
            if (prev_en !== 1'b1) begin
                rx_q.push_back({RS, data});
                latched = {RS, data};
            end else begin
                chk("stable_while_en", {23'b0, RS, data}, {23'b0, latched});
            end
        end
        prev_en = EN;
    end

    function automatic void push_exp_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endfunction

    function automatic void push_exp_valor(bit neg, int mag);
        int pw[5] = '{10000, 1000, 100, 10, 1};
        bit seen = 1'b0;
        int d;
        exp_q.push_back(9'h080);
        exp_q.push_back((neg && mag != 0) ? 9'h12D : 9'h120);
        for (int i = 0; i < 5; i++) begin
            d = (mag / pw[i]) % 10;
            if (d != 0 || seen || i == 4) begin
                exp_q.push_back(9'h130 + 9'(d));
                seen = 1'b1;
            end else begin
                exp_q.push_back(9'h120);
            end
        end
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (ocupado === 1'b0) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle_timeout"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {23'b0, rx_q[i]}, {23'b0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic show(input string tag, input bit neg, input int mag);
        @(negedge clk);
        push_exp_valor(neg, mag);
        sinal_saida = neg;
        saida       = 16'(mag);
        last_neg    = neg;
        last_mag    = mag;
        wait_idle(tag, 600);
        check_rx(tag);
        chk({tag, "_ocupado"}, {31'b0, ocupado}, 32'd0);
    endtask

    initial begin
        int n;
        bit rneg;
        int rmag;

        rst_n       = 1'b0;
        saida       = 16'd0;
        sinal_saida = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", {24'b0, data}, 32'h00);
        chk("reset_en", {31'b0, EN}, 32'd0);
        chk("reset_rs", {31'b0, RS}, 32'd0);
        chk("reset_rw", {31'b0, RW}, 32'd0);
        chk("reset_ocupado", {31'b0, ocupado}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        push_exp_init();
        push_exp_valor(1'b0, 0);
        wait_idle("power_on", 2000);
        check_rx("power_on");
        last_neg = 1'b0;
        last_mag = 0;

        show("positive", 1'b0, 1234);
        show("max_neg", 1'b1, 65535);
        show("neg_zero", 1'b1, 0);

        // Change the input while the refresh for 7 is still being written.
        @(negedge clk);
        push_exp_valor(1'b0, 7);
        push_exp_valor(1'b0, 9);
        saida       = 16'd7;
        sinal_saida = 1'b0;
        n = 0;
        while (rx_q.size() < 3 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("change_wait_escreve", 32'(rx_q.size() >= 3), 32'd1);
        chk("change_ocupado_busy", {31'b0, ocupado}, 32'd1);
        saida = 16'd9;
        wait_idle("change_refresh", 1200);
        check_rx("change_refresh");
        last_neg = 1'b0;
        last_mag = 9;

        show("sign_pos", 1'b0, 5);
        show("sign_only", 1'b1, 5);

        for (int k = 0; k < 6; k++) begin
            do begin
                rneg = 1'($urandom_range(0, 1));
                rmag = int'($urandom_range(0, 65535));
            end while ((rneg == last_neg && rmag == last_mag) || (rneg == 1'b0 && rmag == 4321));
            show($sformatf("random%0d", k), rneg, rmag);
        end

        // Reset in the middle of an EN pulse.
        @(negedge clk);
        saida       = 16'd4321;
        sinal_saida = 1'b0;
        n = 0;
        while (EN !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("midpulse_en_seen", {31'b0, EN}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_data", {24'b0, data}, 32'h00);
        chk("midreset_en", {31'b0, EN}, 32'd0);
        chk("midreset_rs", {31'b0, RS}, 32'd0);
        chk("midreset_rw", {31'b0, RW}, 32'd0);
        chk("midreset_ocupado", {31'b0, ocupado}, 32'd1);
        rx_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp_init();
        push_exp_valor(1'b0, 4321);
        wait_idle("restart", 2000);
        check_rx("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_resultado.md
# lcd_resultado

Downstream consumer of the calculator result: takes the signed-magnitude result (`saida`, `sinal_saida`) and drives an HD44780-compatible character LCD in 8-bit mode. The block runs the power-on initialisation sequence. Whenever the shown value differs from the input, it converts the 16-bit magnitude to decimal and rewrites line 1 with a sign and a 5-digit field.

## Interface
- `DELAY_INIT`, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- `DELAY_CMD`, 2000: cycles after each byte, except clear.
- `DELAY_CLEAR`, 82000: cycles after command 0x01.
- `EN_HIGH`, 12: cycles `EN` is held high per byte.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `saida`  in  16  result magnitude, unsigned.
- `sinal_saida`  in  1  result sign; 1 = negative.
- `data`  out  8  LCD data bus.
- `EN`  out  1  LCD enable strobe.
- `RS`  out  1  0 = command, 1 = character.
- `RW`  out  1  always 0 (write only).
- `ocupado`  out  1  high during init, conversion or writing.

## Operation
- FSM states: `ESPERA_INIT`, `INIT`, `OCIOSO`, `CONVERTE`, `ESCREVE`.
- **`ESPERA_INIT`:** count `DELAY_INIT` cycles, then go to `INIT`.
- **`INIT`:** write commands 0x38, 0x0C, 0x06, 0x01 with `RS`=0. Then force one refresh by entering `CONVERTE` with the current inputs.
- **`OCIOSO`:** on every cycle, compare {`sinal_saida`,`saida`} with the last-shown register. If they differ, capture both into it and enter `CONVERTE`.
- **`CONVERTE`:**
  - Sequential double-dabble, one shift per cycle, 16 cycles.
  - Produces 5 BCD digits; the maximum value is 65535.
- **`ESCREVE`:** emit 7 bytes.
  - Byte 1: command 0x80 (`RS`=0).
  - Bytes 2–7: `RS`=1. First a sign character, then the digits, most significant first.
  - Sign: 0x2D if the sign is set and the magnitude is non-zero. Otherwise 0x20, so negative zero displays as positive.
  - Digits: 0x30+d. Leading zeros become 0x20, except the units digit, which is always printed.
- After `ESCREVE`, return to `OCIOSO`.
- Input changes during `CONVERTE` or `ESCREVE` are ignored. After returning to `OCIOSO`, the comparison triggers a further refresh, so the final display always matches the latest stable input.
- A change of sign alone also triggers a refresh.

## Timing
- **Reset values:** `data`=0x00, `EN`=0, `RS`=0, `RW`=0, `ocupado`=1. The last-shown register is cleared.
- **Asserting `rst_n` mid-operation:** outputs take their reset values immediately, including `EN` dropping mid-pulse. The FSM restarts at `ESPERA_INIT`.
- **Byte write, three phases:**
  - SETUP: `data` and `RS` driven, `EN`=0, 1 cycle.
  - PULSE: `EN`=1 for `EN_HIGH` cycles.
  - HOLD: `EN`=0, with `data` and `RS` held, for `DELAY_CMD` cycles, or `DELAY_CLEAR` after 0x01.
- `data` and `RS` never change while `EN`=1.
- **Refresh latency:** input change in `OCIOSO` → captured on the next edge → 16 conversion cycles → first SETUP cycle.
- **Refresh duration:** 7·(1+`EN_HIGH`+`DELAY_CMD`) cycles.
- **`ocupado`:** falls in the first `OCIOSO` cycle and rises in the same cycle as the capture.

## Structure
- Shared package `lcd_pkg` holds:
  - the state encoding;
  - command constants (function set 0x38, display on 0x0C, entry mode 0x06, clear 0x01, set DDRAM line 1 0x80);
  - ASCII constants (space 0x20, minus 0x2D, digit zero 0x30).
- Sub-module `bin_para_bcd` implements the sequential double dabble.
  - Ports: `clk`, `rst_n`, `inicia`, `bin[15:0]`, `bcd[19:0]`, `pronto`.
  - `pronto` pulses 1 cycle after the 16th shift.
- The byte-write phase counter and the delay counter live in the top module.

## Test plan
All tests use bench parameters `DELAY_INIT`=20, `DELAY_CMD`=4, `DELAY_CLEAR`=8, `EN_HIGH`=2.
- **Power-on:** release reset with `saida`=0, `sinal_saida`=0.
  - Expect `EN` pulses latching 0x38, 0x0C, 0x06, 0x01 with `RS`=0.
  - Then 0x80 followed by 0x20 ×5 and 0x30.
  - `ocupado` falls afterwards.
- **Positive value:** `saida`=1234, `sinal_saida`=0 → 0x80, then 0x20, 0x20, 0x31, 0x32, 0x33, 0x34 with `RS`=1.
- **Maximum negative:** `saida`=65535, `sinal_saida`=1 → 0x2D, 0x36, 0x35, 0x35, 0x33, 0x35.
- **Negative zero:** `saida`=0, `sinal_saida`=1 after a prior non-zero value → sign byte 0x20, last digit 0x30.
- **Change during refresh:** change 7→9 during `ESCREVE`.
  - The refresh showing 7 completes all 7 bytes.
  - A second refresh follows, showing 9.
  - The bench checks that `data`/`RS` never change while `EN`=1.
- **Reset mid-pulse:** assert `rst_n`=0 while `EN`=1.
  - All outputs are at reset values before the next edge.
  - After release, the init sequence restarts from 0x38.
